// File: rtl/forward_scoreboard_if.sv
// forward_scoreboard_if: decode-side controls/operands into the scoreboard and forward/stall/counter results back
interface forward_scoreboard_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             advance;
    logic             flush;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [REG_W-1:0] id_dest;
    logic             id_wen;
    logic             id_load;
    logic [2:0]       fwd_a;
    logic [2:0]       fwd_b;
    logic             stall;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] fwd_count;
    modport master (
        output advance, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_wen, id_load,
        input  fwd_a, fwd_b, stall, stall_count, fwd_count
    );
    modport slave (
        input  advance, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_wen, id_load,
        output fwd_a, fwd_b, stall, stall_count, fwd_count
    );
endinterface

// File: rtl/forward_scoreboard.sv
// forward_scoreboard: tracks in-flight destinations per stage, drives youngest-wins forward selects,
// load-use stall and saturating stall/forward counters
module forward_scoreboard #(
    parameter int REG_W      = 5,
    parameter int STAGES     = 3,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16
) (
    input logic              CLK,
    input logic              RST,
    forward_scoreboard_if.slave sb
);
    logic [STAGES:1]  v;
    logic [STAGES:1]  ld;
    logic [REG_W-1:0] dst [1:STAGES];
    logic             haz_a, haz_b, stall, fwd_ev;
    logic [2:0]       fa, fb;
    logic [CNT_W-1:0] stall_cnt, fwd_cnt;

    always_comb begin
        fa    = '0;
        fb    = '0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        // oldest first, so the youngest match is the one left standing
        for (int k = STAGES; k >= 1; k--) begin
            if (v[k] && sb.id_use_rs && sb.id_rs != '0 && dst[k] == sb.id_rs) begin
                haz_a = ld[k] && (k < LOAD_READY);
                fa    = haz_a ? 3'd0 : 3'(k);
            end
            if (v[k] && sb.id_use_rt && sb.id_rt != '0 && dst[k] == sb.id_rt) begin
                haz_b = ld[k] && (k < LOAD_READY);
                fb    = haz_b ? 3'd0 : 3'(k);
            end
        end
    end

    assign stall          = sb.id_valid & ~sb.flush & (haz_a | haz_b);
    assign fwd_ev         = sb.id_valid & ~sb.flush & ~stall & (fa != '0 || fb != '0);
    assign sb.fwd_a       = fa;
    assign sb.fwd_b       = fb;
    assign sb.stall       = stall;
    assign sb.stall_count = stall_cnt;
    assign sb.fwd_count   = fwd_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v         <= '0;
            ld        <= '0;
            for (int k = 1; k <= STAGES; k++) dst[k] <= '0;
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (sb.advance) begin
            for (int k = 2; k <= STAGES; k++) begin
                v[k]   <= v[k-1];
                ld[k]  <= ld[k-1];
                dst[k] <= dst[k-1];
            end
            v[1]   <= sb.id_valid & sb.id_wen & ~stall & ~sb.flush;
            ld[1]  <= sb.id_load;
            dst[1] <= sb.id_dest;
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (fwd_ev && fwd_cnt != '1) fwd_cnt <= fwd_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_forward_scoreboard.sv
// tb_forward_scoreboard: table-driven cycle vectors through a scoreboard queue, plus saturation and
// mid-stream reset sequences; a CNT_W=2 twin shares the stimulus for counter saturation
module tb_forward_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    forward_scoreboard_if #(.REG_W(5), .CNT_W(16)) sb ();
    forward_scoreboard_if #(.REG_W(5), .CNT_W(2))  sbs ();

    assign sbs.advance   = sb.advance;
    assign sbs.flush     = sb.flush;
    assign sbs.id_valid  = sb.id_valid;
    assign sbs.id_rs     = sb.id_rs;
    assign sbs.id_rt     = sb.id_rt;
    assign sbs.id_use_rs = sb.id_use_rs;
    assign sbs.id_use_rt = sb.id_use_rt;
    assign sbs.id_dest   = sb.id_dest;
    assign sbs.id_wen    = sb.id_wen;
    assign sbs.id_load   = sb.id_load;

    forward_scoreboard #(.REG_W(5), .STAGES(3), .LOAD_READY(2), .CNT_W(16)) dut (
        .CLK(clk), .RST(rst), .sb(sb.slave)
    );
    forward_scoreboard #(.REG_W(5), .STAGES(3), .LOAD_READY(2), .CNT_W(2)) dut_s (
        .CLK(clk), .RST(rst), .sb(sbs.slave)
    );

    typedef struct {
        logic       adv, fl, val;
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] dest;
        logic       wen, ld;
        int         ea, eb, es, sc, fc;
    } vec_t;

    vec_t vecs [24];
    vec_t exp_q [$];

    function automatic vec_t mk(input logic adv, fl, val, input int rs, rt, input logic urs, urt,
                                input int dest, input logic wen, ld, input int ea, eb, es, sc, fc);
        vec_t t;
        t.adv = adv; t.fl = fl; t.val = val;
        t.rs = 5'(rs); t.rt = 5'(rt); t.urs = urs; t.urt = urt;
        t.dest = 5'(dest); t.wen = wen; t.ld = ld;
        t.ea = ea; t.eb = eb; t.es = es; t.sc = sc; t.fc = fc;
        return t;
    endfunction

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t t);
        sb.advance   = t.adv;
        sb.flush     = t.fl;
        sb.id_valid  = t.val;
        sb.id_rs     = t.rs;
        sb.id_rt     = t.rt;
        sb.id_use_rs = t.urs;
        sb.id_use_rt = t.urt;
        sb.id_dest   = t.dest;
        sb.id_wen    = t.wen;
        sb.id_load   = t.ld;
    endtask

    task automatic apply(input vec_t t, input string tag);
        vec_t e;
        @(negedge clk);
        drive(t);
        exp_q.push_back(t);
        #2;
        e = exp_q.pop_front();
        chk({tag, " fwd_a"}, int'(sb.fwd_a), e.ea);
        chk({tag, " fwd_b"}, int'(sb.fwd_b), e.eb);
        chk({tag, " stall"}, int'(sb.stall), e.es);
        chk({tag, " stall_count"}, int'(sb.stall_count), e.sc);
        chk({tag, " fwd_count"}, int'(sb.fwd_count), e.fc);
        chk({tag, " small stall_count"}, int'(sbs.stall_count), sat3(e.sc));
        chk({tag, " small fwd_count"}, int'(sbs.fwd_count), sat3(e.fc));
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, " fwd_a"}, int'(sb.fwd_a), 0);
        chk({tag, " fwd_b"}, int'(sb.fwd_b), 0);
        chk({tag, " stall"}, int'(sb.stall), 0);
        chk({tag, " stall_count"}, int'(sb.stall_count), 0);
        chk({tag, " fwd_count"}, int'(sb.fwd_count), 0);
        chk({tag, " small stall_count"}, int'(sbs.stall_count), 0);
        chk({tag, " small fwd_count"}, int'(sbs.fwd_count), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        //              adv fl val rs  rt urs urt dst wen ld  ea eb es sc fc
        vecs[0]  = mk(1, 0, 1,  1,  2, 1, 1,  3, 1, 0,  0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 1,  3,  2, 1, 1,  6, 1, 0,  1, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 1,  0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 1);
        vecs[3]  = mk(1, 0, 1,  6,  3, 1, 1,  0, 1, 0,  2, 3, 0, 0, 1);
        vecs[4]  = mk(1, 0, 1,  0,  0, 1, 1,  4, 1, 1,  0, 0, 0, 0, 2);
        vecs[5]  = mk(1, 0, 1,  1,  4, 1, 1,  7, 1, 0,  0, 0, 1, 0, 2);
        vecs[6]  = mk(1, 0, 1,  1,  4, 1, 1,  7, 1, 0,  0, 2, 0, 1, 2);
        vecs[7]  = mk(1, 0, 1,  4,  7, 0, 0,  5, 1, 0,  0, 0, 0, 1, 3);
        vecs[8]  = mk(1, 0, 1,  0,  0, 0, 0,  8, 1, 0,  0, 0, 0, 1, 3);
        vecs[9]  = mk(1, 0, 1,  5,  0, 1, 0,  5, 1, 0,  2, 0, 0, 1, 3);
        vecs[10] = mk(1, 0, 1,  5,  8, 1, 1,  5, 1, 1,  1, 2, 0, 1, 4);
        vecs[11] = mk(1, 0, 1,  5,  8, 1, 1,  9, 1, 0,  0, 3, 1, 1, 5);
        vecs[12] = mk(1, 0, 1,  5,  8, 1, 1,  9, 1, 0,  2, 0, 0, 2, 5);
        vecs[13] = mk(1, 1, 1,  9,  0, 1, 0, 10, 1, 0,  1, 0, 0, 2, 6);
        vecs[14] = mk(1, 0, 1, 10,  9, 1, 1,  0, 0, 0,  0, 2, 0, 2, 6);
        vecs[15] = mk(1, 0, 1,  0,  0, 0, 0, 11, 1, 1,  0, 0, 0, 2, 7);
        vecs[16] = mk(1, 1, 1,  0, 11, 0, 1, 14, 1, 0,  0, 0, 0, 2, 7);
        vecs[17] = mk(1, 0, 1, 11,  0, 1, 0, 12, 1, 1,  2, 0, 0, 2, 7);
        for (int i = 18; i < 22; i++)
            vecs[i] = mk(0, 0, 1, 12, 0, 1, 0, 15, 1, 0,  0, 0, 1, 2, 8);
        vecs[22] = mk(1, 0, 1, 12,  0, 1, 0, 15, 1, 0,  0, 0, 1, 2, 8);
        vecs[23] = mk(1, 0, 1, 12,  0, 1, 0,  0, 0, 0,  2, 0, 0, 3, 8);

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        #2;
        chk_cleared("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // self-dependent load chain: stall and forward alternate, pushing both counters past 3
        for (int i = 0; i < 11; i++)
            apply(mk(1, 0, 1, 13, 0, 1, 0, 13, 1, 1,
                     (i > 0 && i % 2 == 0) ? 2 : 0, 0, i % 2,
                     3 + i / 2, 9 + ((i > 0) ? (i - 1) / 2 : 0)), $sformatf("sat%0d", i));

        @(negedge clk);
        drive(mk(1, 0, 1, 13, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("pre_reset stall", int'(sb.stall), 1);
        chk("pre_reset stall_count", int'(sb.stall_count), 8);
        chk("pre_reset fwd_count", int'(sb.fwd_count), 14);
        chk("pre_reset small stall_count", int'(sbs.stall_count), 3);
        chk("pre_reset small fwd_count", int'(sbs.fwd_count), 3);
        rst = 1'b1;
        #1;
        chk_cleared("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        apply(mk(1, 0, 1, 13, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
